// File: rtl/micro_alpha_veryl_iterative_shifter.sv
// Iterative shifter/rotator: STEP bits per cycle, valid/ready on both sides.
// Optional zero flag port enabled by defining MICRO_ALPHA_SHIFTER_ZERO_FLAG_EN.
module micro_alpha_veryl_iterative_shifter #(
  parameter int unsigned WIDTH       = 16,
  parameter int unsigned STEP        = 1,
  parameter int unsigned SHAMT_WIDTH = $clog2(WIDTH)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [3:0]             operation,
  input  logic [WIDTH-1:0]       in,
  input  logic [SHAMT_WIDTH-1:0] amount,
  input  logic                   cin,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [WIDTH-1:0]       out,
  output logic                   cout
`ifdef MICRO_ALPHA_SHIFTER_ZERO_FLAG_EN
  ,
  output logic                   zero
`endif
);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;
  typedef enum logic [3:0] {
    OP_SLL  = 4'd0,
    OP_SRL  = 4'd1,
    OP_SLA  = 4'd2,
    OP_SRA  = 4'd3,
    OP_ROL  = 4'd4,
    OP_ROR  = 4'd5,
    OP_EXT  = 4'd6,
    OP_SWAP = 4'd7,
    OP_NOP  = 4'd8
  } op_t;

  localparam int unsigned HALF = WIDTH / 2;
  localparam logic [SHAMT_WIDTH-1:0] STEP_W = SHAMT_WIDTH'(STEP);

  state_t                 state_q, state_d;
  logic [3:0]             op_q, op_d;
  logic [WIDTH-1:0]       data_q, data_d;
  logic [SHAMT_WIDTH-1:0] rem_q, rem_d;
  logic                   cin_q, cin_d;
  logic                   carry_q, carry_d;
  logic [WIDTH-1:0]       out_q, out_d;
  logic                   cout_q, cout_d;
`ifdef MICRO_ALPHA_SHIFTER_ZERO_FLAG_EN
  logic                   zero_q, zero_d;
`endif

  logic [SHAMT_WIDTH-1:0] step_amt;
  logic [SHAMT_WIDTH-1:0] rem_next;
  logic [WIDTH-1:0]       shift_data;
  logic                   shift_carry;
  logic [WIDTH-1:0]       imm_data;
  logic                   imm_carry;
  logic                   is_shift;

  // One BUSY cycle: up to STEP single-bit moves, gated by the remaining distance.
  always_comb begin
    step_amt    = (rem_q < STEP_W) ? rem_q : STEP_W;
    rem_next    = rem_q - step_amt;
    shift_data  = data_q;
    shift_carry = carry_q;
    for (int unsigned i = 0; i < STEP; i++) begin
      if (SHAMT_WIDTH'(i) < step_amt) begin
        case (op_q)
          OP_SLL, OP_SLA: begin
            shift_carry = shift_data[WIDTH-1];
            shift_data  = {shift_data[WIDTH-2:0], cin_q};
          end
          OP_SRL: begin
            shift_carry = shift_data[0];
            shift_data  = {cin_q, shift_data[WIDTH-1:1]};
          end
          OP_SRA: begin
            shift_carry = shift_data[0];
            shift_data  = {shift_data[WIDTH-1], shift_data[WIDTH-1:1]};
          end
          OP_ROL: begin
            shift_carry = shift_data[WIDTH-1];
            shift_data  = {shift_data[WIDTH-2:0], shift_data[WIDTH-1]};
          end
          OP_ROR: begin
            shift_carry = shift_data[0];
            shift_data  = {shift_data[0], shift_data[WIDTH-1:1]};
          end
          default: ;
        endcase
      end
    end
  end

  // Results finished on the accept edge; zero-distance shifts fall into the pass-through case.
  always_comb begin
    imm_data  = in;
    imm_carry = 1'b0;
    is_shift  = (operation <= OP_ROR);
    case (operation)
      OP_EXT: begin
        imm_data  = {{HALF{in[HALF-1]}}, in[HALF-1:0]};
        imm_carry = in[HALF-1];
      end
      OP_SWAP: imm_data = {in[HALF-1:0], in[WIDTH-1:HALF]};
      default: ;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    data_d    = data_q;
    rem_d     = rem_q;
    cin_d     = cin_q;
    carry_d   = carry_q;
    out_d     = out_q;
    cout_d    = cout_q;
`ifdef MICRO_ALPHA_SHIFTER_ZERO_FLAG_EN
    zero_d    = zero_q;
`endif
    in_ready  = (state_q == S_IDLE);
    out_valid = (state_q == S_DONE);
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          op_d    = operation;
          data_d  = in;
          rem_d   = amount;
          cin_d   = cin;
          carry_d = 1'b0;
          if (is_shift && (amount != '0)) begin
            state_d = S_BUSY;
          end else begin
            state_d = S_DONE;
            out_d   = imm_data;
            cout_d  = imm_carry;
`ifdef MICRO_ALPHA_SHIFTER_ZERO_FLAG_EN
            zero_d  = (imm_data == '0);
`endif
          end
        end
      end
      S_BUSY: begin
        data_d  = shift_data;
        carry_d = shift_carry;
        rem_d   = rem_next;
        if (rem_next == '0) begin
          state_d = S_DONE;
          out_d   = shift_data;
          cout_d  = shift_carry;
`ifdef MICRO_ALPHA_SHIFTER_ZERO_FLAG_EN
          zero_d  = (shift_data == '0);
`endif
        end
      end
      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      op_q    <= '0;
      data_q  <= '0;
      rem_q   <= '0;
      cin_q   <= 1'b0;
      carry_q <= 1'b0;
      out_q   <= '0;
      cout_q  <= 1'b0;
`ifdef MICRO_ALPHA_SHIFTER_ZERO_FLAG_EN
      zero_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      data_q  <= data_d;
      rem_q   <= rem_d;
      cin_q   <= cin_d;
      carry_q <= carry_d;
      out_q   <= out_d;
      cout_q  <= cout_d;
`ifdef MICRO_ALPHA_SHIFTER_ZERO_FLAG_EN
      zero_q  <= zero_d;
`endif
    end
  end

  assign out  = out_q;
  assign cout = cout_q;
`ifdef MICRO_ALPHA_SHIFTER_ZERO_FLAG_EN
  assign zero = zero_q;
`endif

endmodule

// File: tb/tb_micro_alpha_veryl_iterative_shifter.sv
// Directed bench for the iterative shifter: STEP=1 and STEP=4 instances.
module tb_micro_alpha_veryl_iterative_shifter;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_valid4;
  logic        in_ready, in_ready4;
  logic [3:0]  operation;
  logic [15:0] din;
  logic [3:0]  amount;
  logic        cin;
  logic        out_valid, out_valid4;
  logic        out_ready;
  logic [15:0] out_s, out4;
  logic        cout_s, cout4;
`ifdef MICRO_ALPHA_SHIFTER_ZERO_FLAG_EN
  logic        zero_s, zero4;
`endif

  int unsigned checks = 0;
  int unsigned errors = 0;

  always #5 clk = ~clk;

  micro_alpha_veryl_iterative_shifter #(.WIDTH(16), .STEP(1)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .operation(operation), .in(din), .amount(amount), .cin(cin),
    .out_valid(out_valid), .out_ready(out_ready), .out(out_s), .cout(cout_s)
`ifdef MICRO_ALPHA_SHIFTER_ZERO_FLAG_EN
    , .zero(zero_s)
`endif
  );

  micro_alpha_veryl_iterative_shifter #(.WIDTH(16), .STEP(4)) u_dut4 (
    .clk(clk), .rst(rst), .in_valid(in_valid4), .in_ready(in_ready4),
    .operation(operation), .in(din), .amount(amount), .cin(cin),
    .out_valid(out_valid4), .out_ready(out_ready), .out(out4), .cout(cout4)
`ifdef MICRO_ALPHA_SHIFTER_ZERO_FLAG_EN
    , .zero(zero4)
`endif
  );

  typedef struct {
    string       name;
    logic [3:0]  op;
    logic [15:0] d;
    logic [3:0]  a;
    logic        c;
    logic [15:0] eo;
    logic        eco;
    int unsigned elat;
  } vec_t;

  vec_t vecs[16];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic run_op(input bit use4, input string name, input logic [3:0] op,
                        input logic [15:0] d, input logic [3:0] a, input logic c,
                        input logic [15:0] eo, input logic eco, input int unsigned elat);
    int unsigned lat;
    @(negedge clk);
    chk({name, "_in_ready"}, use4 ? in_ready4 : in_ready, 1);
    operation = op; din = d; amount = a; cin = c;
    if (use4) in_valid4 = 1'b1; else in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; in_valid4 = 1'b0;
    lat = 1;
    while (!(use4 ? out_valid4 : out_valid) && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    chk({name, "_latency"}, lat, elat);
    chk({name, "_out"}, use4 ? out4 : out_s, eo);
    chk({name, "_cout"}, use4 ? cout4 : cout_s, eco);
`ifdef MICRO_ALPHA_SHIFTER_ZERO_FLAG_EN
    chk({name, "_zero"}, use4 ? zero4 : zero_s, (eo == 16'h0));
`endif
    @(posedge clk); #1;
  endtask

  initial begin
    vecs[0]  = '{"sll_c0",   4'd0,  16'hA5A5, 4'd1,  1'b0, 16'h4B4A, 1'b1, 2};
    vecs[1]  = '{"sll_c1",   4'd0,  16'hA5A5, 4'd1,  1'b1, 16'h4B4B, 1'b1, 2};
    vecs[2]  = '{"sra_15",   4'd3,  16'h8000, 4'd15, 1'b0, 16'hFFFF, 1'b0, 16};
    vecs[3]  = '{"srl_4",    4'd1,  16'hA5A5, 4'd4,  1'b1, 16'hFA5A, 1'b0, 5};
    vecs[4]  = '{"rol_8",    4'd4,  16'h0123, 4'd8,  1'b0, 16'h2301, 1'b1, 9};
    vecs[5]  = '{"ext",      4'd6,  16'h00FF, 4'd3,  1'b0, 16'hFFFF, 1'b1, 1};
    vecs[6]  = '{"swap",     4'd7,  16'h0123, 4'd5,  1'b1, 16'h2301, 1'b0, 1};
    vecs[7]  = '{"nop",      4'd8,  16'h1234, 4'd7,  1'b1, 16'h1234, 1'b0, 1};
    vecs[8]  = '{"op12_nop", 4'd12, 16'hABCD, 4'd5,  1'b1, 16'hABCD, 1'b0, 1};
    vecs[9]  = '{"sll_k0",   4'd0,  16'hABCD, 4'd0,  1'b1, 16'hABCD, 1'b0, 1};
    vecs[10] = '{"ror_1",    4'd5,  16'h0001, 4'd1,  1'b0, 16'h8000, 1'b1, 2};
    vecs[11] = '{"sla_15",   4'd2,  16'h0001, 4'd15, 1'b0, 16'h8000, 1'b0, 16};
    vecs[12] = '{"sra_pos",  4'd3,  16'h7FFF, 4'd3,  1'b1, 16'h0FFF, 1'b1, 4};
    vecs[13] = '{"srl_15",   4'd1,  16'h8001, 4'd15, 1'b0, 16'h0001, 1'b0, 16};
    vecs[14] = '{"ror_4",    4'd5,  16'h1234, 4'd4,  1'b0, 16'h4123, 1'b0, 5};
    vecs[15] = '{"sll_zero", 4'd0,  16'h8000, 4'd1,  1'b0, 16'h0000, 1'b1, 2};

    rst = 1'b1; in_valid = 1'b0; in_valid4 = 1'b0; out_ready = 1'b1;
    operation = '0; din = '0; amount = '0; cin = 1'b0;
    #12;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out", out_s, 0);
    chk("rst_cout", cout_s, 0);
`ifdef MICRO_ALPHA_SHIFTER_ZERO_FLAG_EN
    chk("rst_zero", zero_s, 0);
`endif
    @(negedge clk); rst = 1'b0;

    for (int i = 0; i < 16; i++)
      run_op(1'b0, vecs[i].name, vecs[i].op, vecs[i].d, vecs[i].a, vecs[i].c,
             vecs[i].eo, vecs[i].eco, vecs[i].elat);

    run_op(1'b1, "s4_sra_15", 4'd3, 16'h8000, 4'd15, 1'b0, 16'hFFFF, 1'b0, 5);
    run_op(1'b1, "s4_sll_5",  4'd0, 16'hA5A5, 4'd5,  1'b0, 16'hB4A0, 1'b0, 3);

    // Output backpressure: DONE must hold its result until out_ready.
    out_ready = 1'b0;
    @(negedge clk);
    operation = 4'd6; din = 16'h00FF; amount = '0; cin = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("bp_out_valid", out_valid, 1);
      chk("bp_out", out_s, 16'hFFFF);
      chk("bp_cout", cout_s, 1);
      chk("bp_in_ready", in_ready, 0);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_release_in_ready", in_ready, 1);
    chk("bp_release_out_valid", out_valid, 0);
    chk("bp_idle_out_hold", out_s, 16'hFFFF);

    // Reset in the middle of a BUSY sequence.
    @(negedge clk);
    operation = 4'd0; din = 16'h0001; amount = 4'd10; cin = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("busy_in_ready", in_ready, 0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_out", out_s, 0);
    chk("midrst_cout", cout_s, 0);
    chk("midrst_in_ready", in_ready, 1);
    @(negedge clk); rst = 1'b0;
    run_op(1'b0, "post_rst_swap", 4'd7, 16'h0123, 4'd0, 1'b0, 16'h2301, 1'b0, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
